// File: rtl/ascii_disp_pkg.sv
// Shared types for the seven-segment ASCII display path.
// Holds the blank code, the scroll state type and the case-fold helper.
package ascii_disp_pkg;

   typedef logic [7:0] ascii_t;

   localparam ascii_t ASCII_BLANK = 8'h20;

   typedef enum logic [1:0] {
      IDLE,
      SCROLL,
      FLUSH
   } scroll_state_t;

   function automatic ascii_t fold_case(input ascii_t c);
      return (c >= 8'h61 && c <= 8'h7A) ? ascii_t'(c - 8'h20) : c;
   endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo: synchronous character buffer with occupancy count and full/empty flags.
// Latency: a pushed character is visible at head_dat the cycle after the push.
// Backpressure: full blocks pushes, empty blocks pops; flush empties in one cycle.
module char_fifo
   import ascii_disp_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush,
   input  logic   push,
   input  ascii_t push_dat,
   input  logic   pop,
   output ascii_t head_dat,
   output logic   full,
   output logic   empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   ascii_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            push_ok;
   logic            pop_ok;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ascii_scroll_ctrl.sv
// ascii_scroll_ctrl: buffers ASCII characters and scrolls them right-to-left across the digits.
// Latency: first character lands on digit 0 TICK_DIV cycles after start; one step per TICK_DIV cycles.
// Backpressure: char_ready = buffer not full; define ASCII_CASE_FOLD_EN to upper-case letters on write.
module ascii_scroll_ctrl
   import ascii_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int FIFO_DEPTH = 16,
   parameter int TICK_DIV   = 25000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              char_data,
   input  logic                    char_valid,
   output logic                    char_ready,
   input  logic                    start,
   input  logic                    clear,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_DIGITS*8-1:0] digit_codes
);

   localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int            BW         = $clog2(NUM_DIGITS + 1);
   localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(NUM_DIGITS);

   scroll_state_t  state;
   scroll_state_t  state_nxt;
   logic [PW-1:0]  presc;
   logic [BW-1:0]  blank_cnt;
   logic [BW-1:0]  blank_nxt;
   ascii_t         digit [NUM_DIGITS];
   ascii_t         wr_char;
   ascii_t         head;
   ascii_t         shift_in;
   logic           full;
   logic           empty;
   logic           push;
   logic           pop;
   logic           tick;
   logic           step;
   logic           done_nxt;

`ifdef ASCII_CASE_FOLD_EN
   assign wr_char = fold_case(char_data);
`else
   assign wr_char = char_data;
`endif

   assign char_ready = !full;
   assign push       = char_valid && char_ready && !clear;
   assign tick       = (state != IDLE) && (presc == TICK_LAST);

   char_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (clear),
      .push     (push),
      .push_dat (wr_char),
      .pop      (pop),
      .head_dat (head),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      pop       = 1'b0;
      shift_in  = ASCII_BLANK;
      blank_nxt = blank_cnt;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start)
               state_nxt = SCROLL;
         end
         SCROLL: begin
            if (tick) begin
               step = 1'b1;
               if (!empty) begin
                  shift_in = head;
                  pop      = 1'b1;
               end else begin
                  blank_nxt = BW'(1);
                  state_nxt = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (tick) begin
               step      = 1'b1;
               blank_nxt = blank_cnt + 1'b1;
               if (blank_nxt == BLANK_LAST) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Abort outranks everything, including a step landing in the same cycle.
      if (clear) begin
         state_nxt = IDLE;
         step      = 1'b0;
         pop       = 1'b0;
         blank_nxt = '0;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc     <= '0;
         blank_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         presc     <= (clear || state == IDLE || tick) ? '0 : presc + 1'b1;
         blank_cnt <= blank_nxt;
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            digit[i] <= ASCII_BLANK;
      end else if (clear) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            digit[i] <= ASCII_BLANK;
      end else if (step) begin
         for (int i = NUM_DIGITS - 1; i > 0; i--)
            digit[i] <= digit[i-1];
         digit[0] <= shift_in;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
      assign digit_codes[g*8 +: 8] = digit[g];
   end

endmodule

// File: tb/tb_ascii_scroll_ctrl.sv
// Bench for ascii_scroll_ctrl at 4 digits, 4-entry buffer, 3-cycle step.
// Honours ASCII_CASE_FOLD_EN when deciding what a lowercase push should display.
module tb_ascii_scroll_ctrl;

   localparam int ND = 4;
   localparam int FD = 4;
   localparam int TD = 3;

`ifdef ASCII_CASE_FOLD_EN
   localparam logic [7:0] SHOWN_A = 8'h41;
`else
   localparam logic [7:0] SHOWN_A = 8'h61;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [7:0]      char_data = '0;
   logic            char_valid = 1'b0;
   logic            start = 1'b0;
   logic            clear = 1'b0;
   logic            char_ready;
   logic            busy;
   logic            done;
   logic [ND*8-1:0] digit_codes;

   int checks = 0;
   int errors = 0;

   ascii_scroll_ctrl #(
      .NUM_DIGITS (ND),
      .FIFO_DEPTH (FD),
      .TICK_DIV   (TD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .char_data   (char_data),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .start       (start),
      .clear       (clear),
      .busy        (busy),
      .done        (done),
      .digit_codes (digit_codes)
   );

   always #5 clk = ~clk;

   // Reference: a character queue, a display array and a countdown to the next step.
   logic [7:0] mq[$];
   logic [7:0] mdisp[ND];
   bit         m_on;
   bit         m_fl;
   bit         m_done;
   int         m_presc;
   int         m_blanks;

   function automatic logic [7:0] shown(input logic [7:0] c);
`ifdef ASCII_CASE_FOLD_EN
      if (c >= 8'h61 && c <= 8'h7a)
         return c - 8'd32;
`endif
      return c;
   endfunction

   function automatic void m_reset();
      mq.delete();
      for (int i = 0; i < ND; i++)
         mdisp[i] = 8'h20;
      m_on     = 0;
      m_fl     = 0;
      m_done   = 0;
      m_presc  = 0;
      m_blanks = 0;
   endfunction

   function automatic void m_apply(input bit v, input logic [7:0] d, input bit st, input bit cl);
      bit rdy;
      bit tick;
      rdy    = (mq.size() < FD);
      m_done = 0;
      if (cl) begin
         m_reset();
         return;
      end
      tick = m_on && (m_presc == TD - 1);
      if (m_on)
         m_presc = tick ? 0 : m_presc + 1;
      if (tick) begin
         for (int i = ND - 1; i > 0; i--)
            mdisp[i] = mdisp[i-1];
         if (!m_fl && mq.size() > 0) begin
            mdisp[0] = mq.pop_front();
         end else begin
            mdisp[0] = 8'h20;
            m_blanks = m_fl ? m_blanks + 1 : 1;
            m_fl     = 1;
            if (m_blanks == ND) begin
               m_on   = 0;
               m_fl   = 0;
               m_done = 1;
            end
         end
      end else if (!m_on && st) begin
         m_on    = 1;
         m_presc = 0;
      end
      if (v && rdy)
         mq.push_back(shown(d));
   endfunction

   function automatic logic [63:0] m_out();
      logic [31:0] dg;
      for (int i = 0; i < ND; i++)
         dg[i*8 +: 8] = mdisp[i];
      return {29'b0, dg, (mq.size() < FD), m_on, m_done};
   endfunction

   function automatic logic [63:0] dut_out();
      return {29'b0, digit_codes, char_ready, busy, done};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input bit v, input logic [7:0] d, input bit st, input bit cl);
      char_valid = v;
      char_data  = d;
      start      = st;
      clear      = cl;
      m_apply(v, d, st, cl);
      @(posedge clk);
      #1;
      chk("model", dut_out(), m_out());
      char_valid = 1'b0;
      start      = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 8'h00, 0, 0);
   endtask

   task automatic reset_vals(input string nm);
      chk({nm, "_digits"}, digit_codes, 32'h20202020);
      chk({nm, "_ready"}, char_ready, 1'b1);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_done"}, done, 1'b0);
   endtask

   task automatic do_reset(input string nm);
      rst_n      = 1'b0;
      char_valid = 1'b0;
      start      = 1'b0;
      clear      = 1'b0;
      #2;
      m_reset();
      reset_vals(nm);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      reset_vals({nm, "_post"});
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (!done && n < 60) begin
         idle(1);
         n++;
      end
      chk({nm, "_done"}, done, 1'b1);
      chk({nm, "_blank"}, digit_codes, 32'h20202020);
      idle(1);
   endtask

   typedef struct {
      bit          v;
      logic [7:0]  d;
      bit          st;
      bit          cl;
      logic [31:0] dig;
      bit          rdy;
      bit          bsy;
      bit          dn;
   } vec_t;

   vec_t tbl[22];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      int seen;
      // Push "AB", start, then watch each step until the done pulse.
      tbl[0]  = '{1, 8'h41, 0, 0, 32'h20202020, 1, 0, 0};
      tbl[1]  = '{1, 8'h42, 0, 0, 32'h20202020, 1, 0, 0};
      tbl[2]  = '{0, 8'h00, 1, 0, 32'h20202020, 1, 1, 0};
      tbl[3]  = '{0, 8'h00, 0, 0, 32'h20202020, 1, 1, 0};
      tbl[4]  = '{0, 8'h00, 0, 0, 32'h20202020, 1, 1, 0};
      tbl[5]  = '{0, 8'h00, 0, 0, 32'h20202041, 1, 1, 0};
      tbl[6]  = '{0, 8'h00, 0, 0, 32'h20202041, 1, 1, 0};
      tbl[7]  = '{0, 8'h00, 0, 0, 32'h20202041, 1, 1, 0};
      tbl[8]  = '{0, 8'h00, 0, 0, 32'h20204142, 1, 1, 0};
      tbl[9]  = '{0, 8'h00, 0, 0, 32'h20204142, 1, 1, 0};
      tbl[10] = '{0, 8'h00, 0, 0, 32'h20204142, 1, 1, 0};
      tbl[11] = '{0, 8'h00, 0, 0, 32'h20414220, 1, 1, 0};
      tbl[12] = '{0, 8'h00, 0, 0, 32'h20414220, 1, 1, 0};
      tbl[13] = '{0, 8'h00, 0, 0, 32'h20414220, 1, 1, 0};
      tbl[14] = '{0, 8'h00, 0, 0, 32'h41422020, 1, 1, 0};
      tbl[15] = '{0, 8'h00, 0, 0, 32'h41422020, 1, 1, 0};
      tbl[16] = '{0, 8'h00, 0, 0, 32'h41422020, 1, 1, 0};
      tbl[17] = '{0, 8'h00, 0, 0, 32'h42202020, 1, 1, 0};
      tbl[18] = '{0, 8'h00, 0, 0, 32'h42202020, 1, 1, 0};
      tbl[19] = '{0, 8'h00, 0, 0, 32'h42202020, 1, 1, 0};
      tbl[20] = '{0, 8'h00, 0, 0, 32'h20202020, 1, 0, 1};
      tbl[21] = '{0, 8'h00, 0, 0, 32'h20202020, 1, 0, 0};

      #1;
      do_reset("reset");

      for (int i = 0; i < 22; i++) begin
         cyc(tbl[i].v, tbl[i].d, tbl[i].st, tbl[i].cl);
         chk($sformatf("vec%0d", i), {29'b0, digit_codes, char_ready, busy, done},
             {29'b0, tbl[i].dig, tbl[i].rdy, tbl[i].bsy, tbl[i].dn});
      end

      // Five pushes into four entries: the fifth is refused.
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'(8'h31 + i), 0, 0);
         chk($sformatf("full_ready%0d", i), char_ready, (i < 3));
      end
      cyc(0, 8'h00, 1, 0);
      idle(12);
      chk("full_four", digit_codes, 32'h31323334);
      idle(3);
      chk("full_fifth_dropped", digit_codes, 32'h32333420);
      wait_done("full");

      // Push landing on the same edge as a pop.
      cyc(1, 8'h41, 0, 0);
      cyc(1, 8'h42, 0, 0);
      cyc(0, 8'h00, 1, 0);
      idle(2);
      cyc(1, 8'h43, 0, 0);
      chk("pushpop_first", digit_codes, 32'h20202041);
      idle(6);
      chk("pushpop_order", digit_codes, 32'h20414243);
      idle(3);
      chk("pushpop_tail", digit_codes, 32'h41424320);
      wait_done("pushpop");

      // Clear mid-scroll: blank, idle, buffer emptied, no done.
      cyc(1, 8'h58, 0, 0);
      cyc(1, 8'h59, 0, 0);
      cyc(0, 8'h00, 1, 0);
      idle(4);
      chk("clear_pre", digit_codes, 32'h20202058);
      cyc(0, 8'h00, 0, 1);
      chk("clear_digits", digit_codes, 32'h20202020);
      chk("clear_busy", busy, 1'b0);
      chk("clear_ready", char_ready, 1'b1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (done)
            seen++;
      end
      chk("clear_no_done", seen, 0);
      cyc(0, 8'h00, 1, 0);
      idle(3);
      chk("clear_fifo_empty", digit_codes, 32'h20202020);
      chk("clear_restart_busy", busy, 1'b1);
      wait_done("clear_restart");

      // Lowercase handling.
      cyc(1, 8'h61, 0, 0);
      cyc(0, 8'h00, 1, 0);
      idle(3);
      chk("case_fold", digit_codes[7:0], SHOWN_A);
      wait_done("case");

      // Reset mid-scroll.
      cyc(1, 8'h4b, 0, 0);
      cyc(1, 8'h4c, 0, 0);
      cyc(0, 8'h00, 1, 0);
      idle(5);
      chk("midreset_pre", digit_codes, 32'h2020204b);
      do_reset("midreset");

      // Random traffic against the reference.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500)
            do_reset("rand_reset");
         cyc(($urandom_range(0, 2) == 0), 8'($urandom_range(32, 126)),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
